stream_mux_rr: RTL and testbench
================================

Name: stream_mux_rr

Overview:
- Parametrised N-channel, W-bit registered stream multiplexer with valid/ready handshakes on every input and on the output.
- Next generation of the 4-way 16-bit combinational mux.
- Two modes: fixed select (sel_i picks the channel) and round-robin arbitration across valid channels.
- Sits between multiple data producers (CPU/ALU result paths, memory-mapped sources) and a single consumer. Output is registered, which breaks the combinational path.

Parameters:
- WIDTH, 16, data width per channel in bits.
- CHANNELS, 4, number of input channels (2..16; non-power-of-2 allowed).
- SEL_W, $clog2(CHANNELS) (2 at default), width of the select and channel-id fields. Derived; do not override.

Ports:
- clk_i  input  1  clock; all state updates on the rising edge.
- rst_i  input  1  reset, asynchronous, active-high.
- in_data_i  input  CHANNELS*WIDTH  channel k data at bits [k*WIDTH +: WIDTH].
- in_valid_i  input  CHANNELS  per-channel valid.
- in_ready_o  output  CHANNELS  per-channel ready; at most one bit high in any cycle.
- mode_i  input  1  0 = fixed select, 1 = round-robin.
- sel_i  input  SEL_W  channel index used in fixed mode; ignored in round-robin mode.
- out_data_o  output  WIDTH  registered output data.
- out_valid_o  output  1  output holds a valid beat.
- out_ready_i  input  1  consumer accepts the beat.
- out_chan_o  output  SEL_W  source channel of the beat in out_data_o.

Behaviour:
- **Reset (async, while rst_i=1):**
  - out_valid_o=0, out_data_o=0, out_chan_o=0.
  - Round-robin pointer ptr=CHANNELS-1, so channel 0 has first priority after reset.
  - in_ready_o is all-zero while rst_i=1.
- **Load enable:** load_en = !out_valid_o || out_ready_i. Output register is empty, or its beat leaves this cycle.
- **Grant (combinational, evaluated only when load_en=1):**
  - Fixed mode: grant = sel_i if sel_i<CHANNELS and in_valid_i[sel_i]=1; otherwise no grant.
  - Round-robin mode: grant = first k with in_valid_i[k]=1, scanning ptr+1, ptr+2, ... modulo CHANNELS. No valid channel means no grant.
- **Ready:**
  - in_ready_o[k] = load_en && grant exists && grant==k.
  - in_ready_o never depends on other channels' data. It may depend on in_valid_i.
- **Accepted input beat** (valid&ready on channel g), at the clock edge:
  - out_data_o <= channel g data; out_chan_o <= g; out_valid_o <= 1; ptr <= g.
  - ptr updates in both modes.
- **Output beat leaves without a new grant:** out_valid_o <= 0. out_data_o and out_chan_o hold their last values.
- **Backpressure:** while out_valid_o=1 and out_ready_i=0:
  - out_data_o, out_chan_o and out_valid_o are held stable.
  - All in_ready_o bits are 0.
- **Timing:**
  - Latency: input accept edge to out_valid_o is 1 cycle.
  - Throughput: 1 beat/cycle with out_ready_i held high (simultaneous dequeue and load in the same cycle).
- **Mode / select changes:** a change of mode_i or sel_i affects only the next grant. A beat already in the output register is never altered.
- **Fairness:** in round-robin mode with all channels continuously valid and out_ready_i=1, grants cycle 0,1,2,...,CHANNELS-1,0. No channel waits more than CHANNELS-1 accepted beats.
- **Reset mid-operation:** asserting rst_i drops out_valid_o immediately (asynchronously). The held beat is discarded and ptr returns to CHANNELS-1.
- **Input data contract:** data is sampled only on the accepting edge. Producers must hold data stable while valid and not ready; the block does not check this.

Test Plan:
1. **Reset:** rst_i=1 with all in_valid_i=1 → out_valid_o=0, out_data_o=0x0000, in_ready_o=4'b0000. Release reset in round-robin mode with ch0..3 = 0x1234/0x9876/0xAAAA/0x5555 all valid and out_ready_i=1 → first beat 0x1234 with out_chan_o=0, one cycle after release.
2. **Fixed mode sweep:** mode_i=0, same data, sel_i stepped 00,01,10,11 each cycle, out_ready_i=1 → outputs 0x1234, 0x9876, 0xAAAA, 0x5555 in successive cycles, each 1 cycle after its select. Only in_ready_o[sel_i] is high.
3. **Round-robin fairness:** mode_i=1, all valid, out_ready_i=1 for 8 cycles → out_chan_o sequence 0,1,2,3,0,1,2,3. Data matches the channel each cycle.
4. **Backpressure:** out_ready_i=0 for 5 cycles after the 0x9876 beat loads → out_data_o=0x9876 and out_valid_o=1 stay stable, in_ready_o=0. When out_ready_i rises, the next beat is 0xAAAA (ch2) on the following cycle.
5. **Sparse valid / skip:** mode_i=1, only ch1 and ch3 valid → out_chan_o alternates 1,3,1,3. No gaps while out_ready_i=1. No valid inputs → out_valid_o falls to 0 after the last beat drains.
6. **Mid-stream reset and invalid select:**
   - rst_i pulsed asynchronously (mid-cycle) while out_valid_o=1 → out_valid_o drops immediately; after release, ch0 is granted first.
   - Separately, CHANNELS=3 with mode_i=0 and sel_i=3 → no grant, in_ready_o=0, out_valid_o stays 0.

Source files
------------

// File: rtl/stream_mux_rr_if.sv
// Handshake bundle for stream_mux_rr: N input streams, one registered output
// stream, plus the mode/select controls.
interface stream_mux_rr_if #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned CHANNELS = 4
);
  localparam int unsigned SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic [CHANNELS*WIDTH-1:0] in_data_i;
  logic [CHANNELS-1:0]       in_valid_i;
  logic [CHANNELS-1:0]       in_ready_o;
  logic                      mode_i;
  logic [SEL_W-1:0]          sel_i;
  logic [WIDTH-1:0]          out_data_o;
  logic                      out_valid_o;
  logic                      out_ready_i;
  logic [SEL_W-1:0]          out_chan_o;

  // Producer/consumer side (testbench or surrounding logic).
  modport master (
    output in_data_i, in_valid_i, mode_i, sel_i, out_ready_i,
    input  in_ready_o, out_data_o, out_valid_o, out_chan_o
  );

  // Multiplexer side.
  modport slave (
    input  in_data_i, in_valid_i, mode_i, sel_i, out_ready_i,
    output in_ready_o, out_data_o, out_valid_o, out_chan_o
  );
endinterface

// File: rtl/stream_mux_rr.sv
// N-channel registered stream multiplexer with fixed-select and round-robin
// arbitration. The output register reloads whenever it is empty or draining.
module stream_mux_rr #(
  parameter int unsigned WIDTH    = 16,
  parameter int unsigned CHANNELS = 4
) (
  input logic           clk_i,
  input logic           rst_i,
  stream_mux_rr_if.slave bus
);
  localparam int unsigned SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic [WIDTH-1:0]    data_q, data_d;
  logic [SEL_W-1:0]    chan_q, chan_d;
  logic [SEL_W-1:0]    ptr_q, ptr_d;
  logic                valid_q, valid_d;

  logic                load_en;
  logic                gnt_any;
  logic [SEL_W-1:0]    gnt_idx;
  logic [WIDTH-1:0]    gnt_data;
  logic [CHANNELS-1:0] ready;

  assign load_en = !valid_q || bus.out_ready_i;

  // Grant selection: fixed index, or first valid channel after the last winner.
  always_comb begin
    int unsigned k;
    gnt_any = 1'b0;
    gnt_idx = '0;
    k       = 0;
    if (bus.mode_i) begin
      for (int unsigned off = 1; off <= CHANNELS; off++) begin
        k = (32'(ptr_q) + off) % CHANNELS;
        if (!gnt_any && bus.in_valid_i[k]) begin
          gnt_any = 1'b1;
          gnt_idx = SEL_W'(k);
        end
      end
    end else begin
      // Out-of-range selects match no channel, so they never grant.
      for (int unsigned c = 0; c < CHANNELS; c++) begin
        if (32'(bus.sel_i) == c && bus.in_valid_i[c]) begin
          gnt_any = 1'b1;
          gnt_idx = SEL_W'(c);
        end
      end
    end
  end

  // Data mux and one-hot ready for the granted channel.
  always_comb begin
    gnt_data = '0;
    ready    = '0;
    for (int unsigned c = 0; c < CHANNELS; c++) begin
      if (gnt_idx == SEL_W'(c)) begin
        gnt_data = bus.in_data_i[c*WIDTH +: WIDTH];
        ready[c] = !rst_i && load_en && gnt_any;
      end
    end
  end

  // Next-state for the output register and round-robin pointer.
  always_comb begin
    data_d  = data_q;
    chan_d  = chan_q;
    valid_d = valid_q;
    ptr_d   = ptr_q;
    if (load_en) begin
      if (gnt_any) begin
        data_d  = gnt_data;
        chan_d  = gnt_idx;
        valid_d = 1'b1;
        ptr_d   = gnt_idx;
      end else begin
        valid_d = 1'b0;
      end
    end
  end

  // State registers; reset leaves ptr at the last channel so channel 0 wins first.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_q  <= '0;
      chan_q  <= '0;
      valid_q <= 1'b0;
      ptr_q   <= SEL_W'(CHANNELS - 1);
    end else begin
      data_q  <= data_d;
      chan_q  <= chan_d;
      valid_q <= valid_d;
      ptr_q   <= ptr_d;
    end
  end

  assign bus.in_ready_o  = ready;
  assign bus.out_data_o  = data_q;
  assign bus.out_valid_o = valid_q;
  assign bus.out_chan_o  = chan_q;
endmodule

// File: tb/tb_stream_mux_rr.sv
// Bench for stream_mux_rr: a 4-channel and a 3-channel instance share stimulus
// and are both checked every cycle against a behavioural model.
module tb_stream_mux_rr;
  logic        clk;
  logic        rst;
  logic [63:0] in_data;
  logic [3:0]  in_valid;
  logic        mode;
  logic [1:0]  sel;
  logic        out_ready;

  int n_checks = 0;
  int n_errors = 0;

  stream_mux_rr_if #(.WIDTH(16), .CHANNELS(4)) ifa ();
  stream_mux_rr_if #(.WIDTH(16), .CHANNELS(3)) ifb ();

  assign ifa.in_data_i   = in_data;
  assign ifa.in_valid_i  = in_valid;
  assign ifa.mode_i      = mode;
  assign ifa.sel_i       = sel;
  assign ifa.out_ready_i = out_ready;
  assign ifb.in_data_i   = in_data[47:0];
  assign ifb.in_valid_i  = in_valid[2:0];
  assign ifb.mode_i      = mode;
  assign ifb.sel_i       = sel;
  assign ifb.out_ready_i = out_ready;

  stream_mux_rr #(.WIDTH(16), .CHANNELS(4)) dut_a (.clk_i(clk), .rst_i(rst), .bus(ifa));
  stream_mux_rr #(.WIDTH(16), .CHANNELS(3)) dut_b (.clk_i(clk), .rst_i(rst), .bus(ifb));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model state, one entry per instance.
  int chans [2] = '{4, 3};
  bit m_valid [2];
  int m_data  [2];
  int m_chan  [2];
  int m_last  [2];   // channel granted most recently

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      m_valid[i] = 0;
      m_data[i]  = 0;
      m_chan[i]  = 0;
      m_last[i]  = chans[i] - 1;
    end
  endfunction

  // Which channel the specification says wins this cycle, or -1.
  function automatic int model_grant(int inst);
    int c = chans[inst];
    if (!mode) begin
      if (int'(sel) < c && in_valid[sel]) return int'(sel);
      return -1;
    end
    for (int o = 1; o <= c; o++) begin
      int k = (m_last[inst] + o) % c;
      if (in_valid[k]) return k;
    end
    return -1;
  endfunction

  function automatic logic [31:0] dut_ready(int inst);
    return (inst == 0) ? {28'd0, ifa.in_ready_o} : {29'd0, ifb.in_ready_o};
  endfunction
  function automatic logic [31:0] dut_valid(int inst);
    return (inst == 0) ? {31'd0, ifa.out_valid_o} : {31'd0, ifb.out_valid_o};
  endfunction
  function automatic logic [31:0] dut_data(int inst);
    return (inst == 0) ? {16'd0, ifa.out_data_o} : {16'd0, ifb.out_data_o};
  endfunction
  function automatic logic [31:0] dut_chan(int inst);
    return (inst == 0) ? {30'd0, ifa.out_chan_o} : {30'd0, ifb.out_chan_o};
  endfunction

  task automatic check_outputs(input string pfx);
    for (int i = 0; i < 2; i++) begin
      check_eq($sformatf("%s.valid[C=%0d]", pfx, chans[i]), dut_valid(i), 32'(m_valid[i]));
      check_eq($sformatf("%s.data[C=%0d]",  pfx, chans[i]), dut_data(i),  32'(m_data[i]));
      check_eq($sformatf("%s.chan[C=%0d]",  pfx, chans[i]), dut_chan(i),  32'(m_chan[i]));
    end
  endtask

  // One clock cycle: inputs are already applied; check ready, clock, check outputs.
  task automatic step();
    int  g  [2];
    bit  le [2];
    #1;
    for (int i = 0; i < 2; i++) begin
      le[i] = !m_valid[i] || out_ready;
      g[i]  = (le[i] && !rst) ? model_grant(i) : -1;
      check_eq($sformatf("ready[C=%0d]", chans[i]), dut_ready(i),
               (g[i] >= 0) ? (32'd1 << g[i]) : 32'd0);
    end
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (le[i]) begin
          if (g[i] >= 0) begin
            m_valid[i] = 1;
            m_data[i]  = int'(in_data[g[i]*16 +: 16]);
            m_chan[i]  = g[i];
            m_last[i]  = g[i];
          end else begin
            m_valid[i] = 0;
          end
        end
      end
    end
    #1;
    check_outputs("out");
    @(negedge clk);
  endtask

  // Asynchronous reset pulse placed between clock edges.
  task automatic pulse_reset();
    #1 rst = 1'b1;
    #1;
    model_reset();
    check_outputs("async_rst");
    check_eq("async_rst.ready[C=4]", dut_ready(0), 32'd0);
    check_eq("async_rst.ready[C=3]", dut_ready(1), 32'd0);
    rst = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    in_data   = {16'h5555, 16'hAAAA, 16'h9876, 16'h1234};
    in_valid  = 4'b1111;
    mode      = 1'b1;
    sel       = 2'd0;
    out_ready = 1'b1;
    model_reset();
    @(negedge clk);

    // Reset held with all inputs valid.
    step();
    step();
    rst = 1'b0;
    step();
    check_eq("first_beat_chan", dut_chan(0), 32'd0);

    // Fixed-select sweep.
    mode = 1'b0;
    for (int s = 0; s < 4; s++) begin
      sel = 2'(s);
      step();
    end

    // Round-robin fairness.
    mode = 1'b1;
    for (int n = 0; n < 8; n++) step();

    // Backpressure after the ch1 beat loads.
    step();
    step();
    out_ready = 1'b0;
    for (int n = 0; n < 5; n++) step();
    out_ready = 1'b1;
    step();

    // Sparse valids, then drain.
    in_valid = 4'b1010;
    for (int n = 0; n < 6; n++) step();
    in_valid = 4'b0000;
    for (int n = 0; n < 3; n++) step();

    // Mid-stream asynchronous reset, then channel 0 wins first.
    in_valid = 4'b1111;
    step();
    step();
    check_eq("pre_rst_valid", dut_valid(0), 32'd1);
    pulse_reset();
    step();
    check_eq("post_rst_chan", dut_chan(0), 32'd0);

    // Fixed mode with an out-of-range select on the 3-channel instance.
    mode = 1'b0;
    sel  = 2'd3;
    for (int n = 0; n < 3; n++) step();

    // Randomised traffic.
    for (int n = 0; n < 400; n++) begin
      in_data   = {$urandom, $urandom};
      in_valid  = 4'($urandom);
      mode      = 1'($urandom);
      sel       = 2'($urandom);
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 39) == 0) pulse_reset();
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
